// File: rtl/mult_hilo_unit.sv
// Iterative shift-add unsigned multiplier with architectural HI/LO registers.
// One product bit retires per cycle; HI/LO update atomically when the last bit retires.
module mult_hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_enable,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sfmux_high,
    input  logic             sf2reg,
    output logic [WIDTH-1:0] sf_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   p_shift;

    // Carry out of the upper-half add shifts into the product MSB.
    always_comb begin
        addend  = p_q[0] ? m_q : '0;
        sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        p_shift = {sum, p_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mult_enable) begin
                    m_d     = a;
                    p_d     = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                p_d   = p_shift;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    hi_d    = p_shift[2*WIDTH-1:WIDTH];
                    lo_d    = p_shift[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        hi     = hi_q;
        lo     = lo_q;
        done   = done_q;
        busy   = (state_q == StRun);
        stall  = busy & sf2reg;
        sf_out = sfmux_high ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: latency, results, ignored restarts, stall/readback,
// back-to-back issue and reset during a multiply.
module tb_mult_hilo_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             mult_enable;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sfmux_high;
    logic             sf2reg;
    logic [WIDTH-1:0] sf_out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    int n_checks = 0;
    int n_fails  = 0;

    mult_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mult_enable (mult_enable),
        .a           (a),
        .b           (b),
        .sfmux_high  (sfmux_high),
        .sf2reg      (sf2reg),
        .sf_out      (sf_out),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .stall       (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges while a multiply is in flight.
    task automatic run_cycles(input int n, input logic [WIDTH-1:0] hold_hi,
                              input logic [WIDTH-1:0] hold_lo);
        for (int i = 0; i < n; i++) begin
            tick();
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("hi_hold", hi, hold_hi);
            check("lo_hold", lo, hold_lo);
        end
    endtask

    task automatic start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a = av;
        b = bv;
        mult_enable = 1'b1;
        tick();
        mult_enable = 1'b0;
        check("busy_start", busy, 1);
        check("done_start", done, 0);
    endtask

    initial begin
        rst = 1'b1;
        mult_enable = 1'b0;
        a = '0;
        b = '0;
        sfmux_high = 1'b0;
        sf2reg = 1'b0;
        tick();
        tick();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // 3*5: busy for 32 cycles, done pulses once
        start(32'd3, 32'd5);
        run_cycles(WIDTH - 1, 32'd0, 32'd0);
        tick();
        check("t1_busy", busy, 0);
        check("t1_done", done, 1);
        check("t1_hi", hi, 0);
        check("t1_lo", lo, 15);
        tick();
        check("t1_done_pulse", done, 0);

        // all-ones squared
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_cycles(WIDTH - 1, 32'd0, 32'd15);
        tick();
        check("t2a_done", done, 1);
        check("t2a_hi", hi, 32'hFFFF_FFFE);
        check("t2a_lo", lo, 32'h0000_0001);
        tick();

        // MSB carry into HI
        start(32'h8000_0000, 32'd2);
        run_cycles(WIDTH - 1, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        check("t2b_hi", hi, 1);
        check("t2b_lo", lo, 0);
        tick();

        // 3*5 with an ignored 7*7 request at k+10, plus stall/readback while running
        start(32'd3, 32'd5);
        run_cycles(9, 32'd1, 32'd0);
        a = 32'd7;
        b = 32'd7;
        mult_enable = 1'b1;
        sf2reg = 1'b1;
        sfmux_high = 1'b0;
        #1;
        check("t4_stall", stall, 1);
        check("t4_sf_lo_old", sf_out, 0);
        sfmux_high = 1'b1;
        #1;
        check("t4_sf_hi_old", sf_out, 1);
        tick();
        mult_enable = 1'b0;
        a = '0;
        b = '0;
        check("t3_busy", busy, 1);
        run_cycles(WIDTH - 11, 32'd1, 32'd0);
        tick();
        check("t3_done", done, 1);
        check("t3_hi", hi, 0);
        check("t3_lo", lo, 15);
        sfmux_high = 1'b0;
        #1;
        check("t4_stall_idle", stall, 0);
        check("t4_sf_lo", sf_out, 15);
        sfmux_high = 1'b1;
        #1;
        check("t4_sf_hi", sf_out, 0);
        sf2reg = 1'b0;
        tick();

        // zero operands still take full latency; then 6*7 issued in its done cycle
        start(32'd0, 32'd0);
        run_cycles(WIDTH - 1, 32'd0, 32'd15);
        tick();
        check("zero_done", done, 1);
        check("zero_lo", lo, 0);
        check("zero_hi", hi, 0);
        start(32'd6, 32'd7);
        run_cycles(WIDTH - 1, 32'd0, 32'd0);
        tick();
        check("t5_done", done, 1);
        check("t5_lo", lo, 42);
        check("t5_hi", hi, 0);
        tick();

        // reset mid-multiply clears everything immediately
        start(32'd9, 32'd9);
        run_cycles(15, 32'd0, 32'd42);
        rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_hi", hi, 0);
        check("t6_lo", lo, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_idle", busy, 0);
        start(32'd2, 32'd2);
        run_cycles(WIDTH - 1, 32'd0, 32'd0);
        tick();
        check("t6_done2", done, 1);
        check("t6_lo2", lo, 4);
        check("t6_hi2", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
